// File: rtl/red_accum_if.sv
// Handshake bundle for red_accum: an input beat channel carrying two
// operands plus a packet delimiter, and an output result channel.
interface red_accum_if #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 16,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_result;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_count
    );
endinterface

// File: rtl/red_accum.sv
// Sequential lane-reduction accumulator. Every accepted beat adds the signed
// sum of all lanes of both operands into a packet accumulator; the last beat
// of a packet publishes a registered result with a sticky overflow flag and
// a saturating beat count.
module red_accum #(
    parameter int DATA_W   = 16,
    parameter int LANE_W   = 8,
    parameter int RES_W    = 16,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input logic       clk,
    input logic       rst,
    red_accum_if.slave bus
);
    localparam int LANES = DATA_W / LANE_W;

    logic [RES_W-1:0] acc_q, acc_d;
    logic             ovfAcc_q, ovfAcc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             outValid_q, outValid_d;
    logic [RES_W-1:0] outResult_q, outResult_d;
    logic             outOvf_q, outOvf_d;
    logic [CNT_W-1:0] outCount_q, outCount_d;

    logic             inReady;
    logic             accept;
    logic [RES_W:0]   beatSum;
    logic [RES_W:0]   full;
    logic             beatOvf;
    logic [RES_W-1:0] nextAcc;
    logic [CNT_W-1:0] cntInc;

    assign inReady = !outValid_q || bus.out_ready;
    assign accept  = bus.in_valid && inReady;

    // Sum every lane of both operands, each sign-extended to RES_W+1 bits.
    always_comb begin
        beatSum = '0;
        for (int i = 0; i < LANES; i++) begin
            beatSum = beatSum
                    + {{(RES_W + 1 - LANE_W){bus.in_a[i*LANE_W + LANE_W - 1]}},
                       bus.in_a[i*LANE_W +: LANE_W]}
                    + {{(RES_W + 1 - LANE_W){bus.in_b[i*LANE_W + LANE_W - 1]}},
                       bus.in_b[i*LANE_W +: LANE_W]};
        end
    end

    // Widen the accumulator by one bit so the top two bits reveal overflow,
    // then wrap or clamp according to the overflow policy.
    always_comb begin
        full    = {acc_q[RES_W-1], acc_q} + beatSum;
        beatOvf = full[RES_W] ^ full[RES_W-1];
        nextAcc = full[RES_W-1:0];
        if ((SATURATE != 0) && beatOvf) begin
            nextAcc = full[RES_W] ? {1'b1, {(RES_W-1){1'b0}}}
                                  : {1'b0, {(RES_W-1){1'b1}}};
        end
        cntInc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state: accumulate mid-packet beats, publish and clear on the last
    // beat, and drop the result once the consumer has taken it.
    always_comb begin
        acc_d       = acc_q;
        ovfAcc_d    = ovfAcc_q;
        cnt_d       = cnt_q;
        outValid_d  = outValid_q;
        outResult_d = outResult_q;
        outOvf_d    = outOvf_q;
        outCount_d  = outCount_q;
        if (accept && bus.in_last) begin
            outResult_d = nextAcc;
            outOvf_d    = ovfAcc_q | beatOvf;
            outCount_d  = cntInc;
            outValid_d  = 1'b1;
            acc_d       = '0;
            ovfAcc_d    = 1'b0;
            cnt_d       = '0;
        end else begin
            if (accept) begin
                acc_d    = nextAcc;
                ovfAcc_d = ovfAcc_q | beatOvf;
                cnt_d    = cntInc;
            end
            if (outValid_q && bus.out_ready) begin
                outValid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any partial packet and pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ovfAcc_q    <= 1'b0;
            cnt_q       <= '0;
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outOvf_q    <= 1'b0;
            outCount_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            ovfAcc_q    <= ovfAcc_d;
            cnt_q       <= cnt_d;
            outValid_q  <= outValid_d;
            outResult_q <= outResult_d;
            outOvf_q    <= outOvf_d;
            outCount_q  <= outCount_d;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid_q;
    assign bus.out_result = outResult_q;
    assign bus.out_ovf    = outOvf_q;
    assign bus.out_count  = outCount_q;
endmodule

// File: doc/red_accum.md
# red_accum

Parametrised, sequential successor to the combinational reduction unit. Each accepted beat contributes the sum of all signed lanes of two operands. Beats accumulate across a packet, and one registered result is emitted per packet. It sits behind the execute stage's reduction path and uses valid/ready handshakes on both sides. With `in_last` tied high it reproduces the single-beat RED result, one cycle late.

## Interface
- `DATA_W`, 16, operand width; must be a multiple of `LANE_W`.
- `LANE_W`, 8, signed lane width.
- `RES_W`, 16, result/accumulator width; must satisfy `RES_W >= LANE_W + clog2(2*DATA_W/LANE_W)`.
- `CNT_W`, 8, beat-counter width.
- `SATURATE`, 0, overflow policy: 0 = wrap modulo 2^`RES_W`; 1 = clamp to signed min/max.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  unit can accept a beat.
- `in_a`  in  `DATA_W`  operand A.
- `in_b`  in  `DATA_W`  operand B.
- `in_last`  in  1  final beat of the packet.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  `RES_W`  signed packet sum.
- `out_ovf`  out  1  sticky flag: signed overflow occurred in this packet.
- `out_count`  out  `CNT_W`  beats in the packet; saturates at 2^`CNT_W`-1.

## Operation
- Lanes:
  - L = `DATA_W`/`LANE_W` per operand, 2L in total.
  - Each lane is sign-extended to `RES_W`+1 bits.
  - The beat sum is the exact signed sum of all 2L lanes.
- Accept condition: `in_valid && in_ready`.
- `in_ready` = `!out_valid || out_ready` (combinational).
- Internal state:
  - accumulator `acc` (`RES_W`).
  - sticky `ovf_acc`.
  - beat counter `cnt`.
  - output registers.
- Per accepted beat:
  - full = sext(`acc`) + beat sum, computed in `RES_W`+1 bits.
  - Overflow occurs when full is outside [-2^(`RES_W`-1), 2^(`RES_W`-1)-1].
  - next = full[`RES_W`-1:0] if `SATURATE`=0.
  - next = clamp(full) if `SATURATE`=1.
  - The overflow flag ORs into `ovf_acc`.
  - `cnt` increments and saturates.
- Beat with `in_last`=0:
  - `acc`, `ovf_acc` and `cnt` update.
  - Outputs are untouched.
- Beat with `in_last`=1:
  - `out_result` <= next.
  - `out_ovf` <= `ovf_acc` | this beat's overflow.
  - `out_count` <= `cnt`+1, saturated.
  - `out_valid` <= 1.
  - `acc`, `ovf_acc` and `cnt` clear to 0 in the same edge.
- `out_valid` clears on `out_valid && out_ready` unless a new last beat is accepted in the same cycle, in which case the new result loads.
- While `out_valid && !out_ready`:
  - `out_result`, `out_ovf` and `out_count` hold stable.
  - `in_ready`=0, so no beats are accepted, including non-last beats.
- A beat presented with `in_valid`=0 has no effect, whatever the operand values.

## Timing
- Reset (asynchronous, any cycle, including mid-packet):
  - `out_valid`=0, `out_result`=0, `out_ovf`=0, `out_count`=0.
  - `acc`=0, `ovf_acc`=0, `cnt`=0.
  - `in_ready`=1.
  - A partial packet is discarded.
- Latency: a last beat accepted at edge t drives `out_valid`=1 and a valid result from t through at least the next edge.
- Throughput: one beat per cycle. A sustained stream of single-beat packets with `out_ready`=1 produces one result per cycle.
- Simultaneous output drain and last-beat accept: the result is replaced with no bubble and `out_valid` stays 1.
- Counter wrap: at 2^`CNT_W`-1 the counter holds; the accumulation continues correctly.

## Test plan
- Reset then single beat, `in_a`=0xFDFC, `in_b`=0xFBFA, `in_last`=1 -> next cycle `out_result`=0xFFEE (-18), `out_count`=1, `out_ovf`=0.
- Single beat `in_a`=`in_b`=0xFFFF -> 0xFFFC. Then back-to-back beat 0x7F7F/0x7F7F -> 0x01FC on the following cycle, with `out_valid` held high.
- Three-beat packet, each beat `in_a`=`in_b`=0x7F7F, `in_last` on beat 3 -> 0x05F4, `out_count`=3, and no output asserted before beat 3.
- 65-beat packet of 0x7F7F/0x7F7F:
  - `SATURATE`=0 -> 0x80FC with `out_ovf`=1.
  - `SATURATE`=1 -> 0x7FFF with `out_ovf`=1.
  - Both: `out_count`=65, and the next packet starts with `ovf`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles with a result pending -> outputs stable, `in_ready`=0, offered beats not consumed. Release -> the pending beat is accepted on the release cycle.
- Reset pulse after 2 beats of a packet -> all outputs 0. A following 1-beat packet 0x0102/0x0304 gives 0x000A, `out_count`=1.
- Random scoreboard of 1000 beats against a behavioural model, both `SATURATE` settings.
